uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_if.sv | 14 +
 rtl/uart_tx_fifo_byte_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter FSM state encoding.
// Used by the transmit block and by the existing receive path.
package uart_pkg;

    localparam int CLK_HZ       = 16_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_START_ENC = 2'd1;
    localparam logic [1:0] ST_DATA_ENC  = 2'd2;
    localparam logic [1:0] ST_STOP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_START = ST_START_ENC,
        ST_DATA  = ST_DATA_ENC,
        ST_STOP  = ST_STOP_ENC
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte input handshake of the buffered UART transmitter, plus FSM state for observation.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; in_data is ignored otherwise.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    tx_state_e  dbg_state;

    modport master (output in_data, in_valid, input in_ready, dbg_state);
    modport slave  (input in_data, in_valid, output in_ready, dbg_state);

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Small synchronous FIFO; power-of-two depth so the pointers wrap on their own.
// Read data is combinational from the head entry; shared with the receive path.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: FIFO-fed, LSB first, idle-high line,
// queued bytes go out back to back with no idle gap between frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int DEPTH        = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    import uart_pkg::*;

    localparam int              CW        = $clog2(DEPTH + 1);
    localparam int              CBW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CBW-1:0]  BAUD_LAST = CBW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e      state_q, state_d;
    logic [CBW-1:0] baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           bit_end;
    logic           push;
    logic           pop;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;

    assign bus.in_ready  = !reset && !fifo_full;
    assign bus.dbg_state = state_q;
    assign push          = bus.in_valid && bus.in_ready;
    assign bit_end       = (baud_q == BAUD_LAST);
    assign tx            = tx_q;
    assign busy          = !reset && ((state_q != ST_IDLE) || (fifo_count != '0));

    byte_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.in_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // tx is registered from the current state, so the line trails the FSM by
    // one cycle: push at E0, pop at E1, start bit on the line from E2.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CBW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when more is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_dout;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level reference model predicts tx, busy and
// in_ready every cycle; directed scenarios add explicit timing checks.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int L1    = (9 + 1) * C;

    logic clk = 1'b0;
    logic reset;
    logic tx, busy, tx2, busy2;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_fifo_if bus();
    uart_tx_fifo_if bus2();

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one entry per accepted byte (accept edge, start cycle on the line).
    logic [7:0] exp_q[$];
    int         fr_acc[$];
    int         fr_start[$];
    int         last_end = 0;
    int         last_start = 0;
    logic       dut_acc, dut2_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic m_tx(input int k);
        foreach (fr_start[i]) begin
            if (k >= fr_start[i] && k < fr_start[i] + L1) begin
                int idx;
                logic [7:0] b;
                idx = (k - fr_start[i]) / C;
                b = exp_q[i];
                if (idx == 0) return 1'b0;
                if (idx <= 8) return b[idx-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic int m_count(input int k);
        int n = 0;
        foreach (fr_acc[i]) begin
            if (fr_acc[i] <= k && fr_start[i] - 1 > k) n++;
        end
        return n;
    endfunction

    function automatic logic m_busy(input int k);
        foreach (fr_acc[i]) begin
            if (fr_acc[i] <= k && k <= fr_start[i] + L1 - 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance one clock: update the model for the coming edge, then compare at the negedge.
    task automatic tick();
        int k;
        int s;
        k = cyc;
        dut_acc  = bus.in_valid && bus.in_ready;
        dut2_acc = bus2.in_valid && bus2.in_ready;
        if (reset) begin
            exp_q.delete();
            fr_acc.delete();
            fr_start.delete();
            last_end = 0;
        end else if (bus.in_valid && m_count(k) < DEPTH) begin
            s = (k + 3 > last_end) ? k + 3 : last_end;
            exp_q.push_back(bus.in_data);
            fr_acc.push_back(k + 1);
            fr_start.push_back(s);
            last_start = s;
            last_end = s + L1;
        end
        @(negedge clk);
        k = cyc;
        check("tx", tx, reset ? 1'b1 : m_tx(k));
        check("busy", busy, reset ? 1'b0 : m_busy(k));
        check("in_ready", bus.in_ready, reset ? 1'b0 : (m_count(k) < DEPTH));
    endtask

    task automatic push(input logic [7:0] b, output int acc_edge);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            tick();
            n++;
        end while (!dut_acc && n < 200);
        if (!dut_acc) check("push_timeout", 32'd0, 32'd1);
        acc_edge = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    task automatic drain();
        while (cyc < last_end + 4) tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, a0, s0, k;
        int acc[6];
        logic [9:0] pat;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data = '0;
        #2;

        // Reset held 3 cycles, then released.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_ready_after", bus.in_ready, 1'b1);
        check("rst_busy_after", busy, 1'b0);
        repeat (3) tick();

        // Single byte 0xA5: exact line pattern and busy window.
        pat = 10'b1101001010;
        push(8'hA5, e);
        check("t2_busy_k0", busy, 1'b1);
        check("t2_tx_k0", tx, 1'b1);
        for (int j = 0; j < 44; j++) begin
            tick();
            k = cyc - e;
            check("t2_tx", tx, (k >= 2 && k < 42) ? pat[(k - 2) / 4] : 1'b1);
            check("t2_busy", busy, (k <= 40) ? 1'b1 : 1'b0);
        end
        drain();

        // Six bytes with in_valid held: five on consecutive edges, sixth after first pop of frame 2.
        for (int i = 0; i < 6; i++) begin
            push(8'(i), e);
            acc[i] = e;
        end
        a0 = acc[0];
        for (int i = 1; i < 5; i++) check("t3_acc_consecutive", acc[i] - a0, i);
        check("t3_acc_sixth", acc[5] - a0, 42);
        drain();

        // Push on the same edge as a pop while three bytes are queued.
        push(8'h3C, e);
        s0 = last_start;
        push(8'hC3, e);
        push(8'h5A, e);
        push(8'h96, e);
        while (cyc < s0 + L1 - 2) tick();
        push(8'h69, e);
        check("t4_acc_edge", e, s0 + L1 - 1);
        check("t4_ready", bus.in_ready, 1'b1);
        drain();

        // Reset during data bit 3 of a 0xFF frame with two more queued.
        push(8'hFF, e);
        s0 = last_start;
        push(8'h12, e);
        push(8'h34, e);
        while (cyc < s0 + 4 * C + 1) tick();
        reset = 1'b1;
        tick();
        check("t5_tx_after_rst", tx, 1'b1);
        check("t5_busy_after_rst", busy, 1'b0);
        reset = 1'b0;
        repeat (100) begin
            tick();
            check("t5_quiet", tx, 1'b1);
        end

        // Randomised traffic with random gaps, including bursts.
        for (int i = 0; i < 16; i++) begin
            push(8'($urandom_range(0, 255)), e);
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 60)) tick();
        end
        drain();

        // Two stop bits: 36 low, 8 high, busy for exactly 45 cycles.
        bus2.in_valid = 1'b1;
        bus2.in_data = 8'h00;
        tick();
        check("t6_accept", dut2_acc, 1'b1);
        e = cyc;
        bus2.in_valid = 1'b0;
        bus2.in_data = 'x;
        check("t6_busy_k0", busy2, 1'b1);
        for (int j = 0; j < 50; j++) begin
            tick();
            k = cyc - e;
            check("t6_tx", tx2, (k >= 2 && k < 38) ? 1'b0 : 1'b1);
            check("t6_busy", busy2, (k <= 44) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
